// File: rtl/fprti_pkg.sv
// rtl/fprti_pkg.sv - shared constants, state enum and operand map for the job loader
package fprti_pkg;

    localparam int FPRTI_NUM_REGS = 15;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } fprti_state_e;

    // Operand word map presented to the intersection unit
    localparam int RO_X = 0;
    localparam int RO_Y = 1;
    localparam int RO_Z = 2;
    localparam int RD_X = 3;
    localparam int RD_Y = 4;
    localparam int RD_Z = 5;
    localparam int P0_X = 6;
    localparam int P0_Y = 7;
    localparam int P0_Z = 8;
    localparam int P1_X = 9;
    localparam int P1_Y = 10;
    localparam int P1_Z = 11;
    localparam int P2_X = 12;
    localparam int P2_Y = 13;
    localparam int P2_Z = 14;

    localparam logic [31:0] FPRTI_RES_TIMEOUT = 32'hFFFF_FFFF;
    localparam logic [31:0] FPRTI_RES_FRAMING = 32'h0000_0000;

endpackage

// File: rtl/fprti_job_loader.sv
// rtl/fprti_job_loader.sv - loads a ray/triangle job, starts the intersection unit, returns its result
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last   job word stream (one word per handshake)
//   fprti_regs                    NUM_REGS x 32-bit operand array, word i at [i*32 +: 32]
//   int_start                     one-cycle start pulse to the intersection unit
//   int_done/int_result           intersection unit completion and return value
//   res_valid/res_ready/res_data/res_err   result handshake, res_err flags framing error or timeout
//
// Optional feature: define FPRTI_TIMEOUT_EN to add a WAIT-state watchdog of
// TIMEOUT_CYCLES cycles; without it WAIT holds until int_done.
module fprti_job_loader
    import fprti_pkg::*;
#(
    parameter int NUM_REGS       = FPRTI_NUM_REGS,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_data,
    input  logic                    in_last,
    output logic [NUM_REGS*32-1:0]  fprti_regs,
    output logic                    int_start,
    input  logic                    int_done,
    input  logic [31:0]             int_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [31:0]             res_data,
    output logic                    res_err
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    // Elaboration-time sanity check keeps the watchdog limit meaningful in every build
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    fprti_state_e           state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_REGS*32-1:0] regs_q, regs_d;
    logic [31:0]            res_data_q, res_data_d;
    logic                   res_err_q, res_err_d;

`ifdef FPRTI_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        regs_d     = regs_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
`ifdef FPRTI_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    regs_d[int'(idx_q)*32 +: 32] = in_data;
                    // in_last must coincide exactly with the final slot; any other
                    // combination is a framing error and the job is dropped
                    if ((idx_q == LAST_IDX) && in_last) begin
                        state_d = ST_START;
                        idx_d   = '0;
                    end else if ((idx_q == LAST_IDX) || in_last) begin
                        state_d    = ST_RESP;
                        idx_d      = '0;
                        res_data_d = FPRTI_RES_FRAMING;
                        res_err_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
`ifdef FPRTI_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                // int_done wins over a watchdog expiry in the same cycle
                if (int_done) begin
                    state_d    = ST_RESP;
                    res_data_d = int_result;
                    res_err_d  = 1'b0;
                end
`ifdef FPRTI_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_RESP;
                    res_data_d = FPRTI_RES_TIMEOUT;
                    res_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            idx_q      <= '0;
            regs_q     <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
`ifdef FPRTI_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            regs_q     <= regs_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
`ifdef FPRTI_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign int_start  = (state_q == ST_START);
    assign res_valid  = (state_q == ST_RESP);
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign fprti_regs = regs_q;

endmodule

// File: tb/tb_fprti_job_loader.sv
// tb/tb_fprti_job_loader.sv - scoreboard bench for fprti_job_loader
module tb_fprti_job_loader;

    localparam int N   = 15;
    localparam int TMO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, in_last;
    logic [31:0]    in_data;
    logic [N*32-1:0] fprti_regs;
    logic           int_start, int_done;
    logic [31:0]    int_result;
    logic           res_valid, res_ready, res_err;
    logic [31:0]    res_data;

    fprti_job_loader #(.NUM_REGS(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .fprti_regs(fprti_regs), .int_start(int_start),
        .int_done(int_done), .int_result(int_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [32:0]      exp_q[$];     // {err, data}
    logic [N*32-1:0]  regs_q[$];
    int               dly_q[$];
    logic [31:0]      ires_q[$];
    int               starts_seen = 0;
    int               starts_exp  = 0;
    int               bp_cycles   = 0;
    int               bp_token    = 0;
    int               stale_tok   = 0;
    bit               aborted     = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wide(string name, logic [N*32-1:0] act, logic [N*32-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int i = 0; i < N; i++) begin
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) begin
                    $display("FAIL %s: word %0d got %08h expected %08h",
                             name, i, act[i*32 +: 32], exp[i*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    // Without the watchdog no delay ever produces a timeout
    function automatic bit expect_timeout(int dly);
`ifdef FPRTI_TIMEOUT_EN
        return (dly == 0) || (dly > TMO);
`else
        return dly < 0;
`endif
    endfunction

    // Reference: a job is well-formed only if it has exactly N words with in_last on the Nth
    function automatic logic [32:0] model(int n, bit last, int dly, logic [31:0] r);
        if (!(n == N && last)) return {1'b1, 32'h0000_0000};
        if (expect_timeout(dly)) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, r};
    endfunction

    task automatic drive_word(logic [31:0] d, bit l);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL in_ready_wait: got 0 expected 1 within 300 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_job(int n, bit last, int dly, logic [31:0] r, bit gaps, bit seq, bit push_exp);
        logic [31:0]     words[N];
        logic [N*32-1:0] w = '0;
        bit good = (n == N) && last;
        for (int i = 0; i < N; i++) begin
            words[i] = seq ? (32'h3F80_0000 + i) : $urandom;
            w[i*32 +: 32] = words[i];
        end
        if (good) begin
            regs_q.push_back(w);
            dly_q.push_back(dly);
            ires_q.push_back(r);
            starts_exp++;
        end
        if (push_exp) exp_q.push_back(model(n, last, dly, r));
        for (int i = 0; i < n; i++) begin
            drive_word(words[i], last && (i == n - 1));
            if (gaps && i < n - 1) begin @(posedge clk); #1; end
        end
        if (good) check("start_latency", int_start, 1);
        else      check("no_start", int_start, 0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(exp_q.size() == 0 && in_ready) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 400) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_wait: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Intersection unit model: answers each start after its configured delay
    initial begin : responder
        int d;
        logic [31:0] r;
        int seen_stale = 0;
        int_done   = 1'b0;
        int_result = '0;
        forever begin
            @(posedge clk); #1;
            if (stale_tok != seen_stale) begin
                seen_stale = stale_tok;
                int_done   = 1'b1;
                int_result = 32'hDEAD_BEEF;
                @(posedge clk); #1;
                int_done   = 1'b0;
                check("stale_done_ignored", res_valid, 0);
            end else if (int_start && !rst && dly_q.size() > 0) begin
                d = dly_q.pop_front();
                r = ires_q.pop_front();
                if (d == 0) begin
`ifdef FPRTI_TIMEOUT_EN
                    repeat (TMO) @(posedge clk);
                    #1;
                    check("tmo_not_early", res_valid, 0);
                    @(posedge clk); #1;
                    check("tmo_latency", res_valid, 1);
`endif
                end else begin
                    repeat (d) @(posedge clk);
                    #1;
                    int_done   = 1'b1;
                    int_result = r;
                    @(posedge clk); #1;
                    int_done   = 1'b0;
                    if (aborted)                  check("late_done_ignored", res_valid, 0);
                    else if (!expect_timeout(d))  check("done_latency", res_valid, 1);
                end
            end
        end
    end

    // Monitor: result scoreboard, hold stability, start pulse and operand checks
    initial begin : monitor
        bit              in_resp = 0;
        bit              last_start = 0;
        int              stall = 0;
        int              seen_bp = 0;
        logic [31:0]     hd;
        logic            hr;
        logic [N*32-1:0] hregs;
        logic [32:0]     e;
        res_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_resp = 0; last_start = 0; res_ready = 1'b1;
                continue;
            end
            if (int_start) begin
                starts_seen++;
                check("start_single", last_start, 0);
                check("in_ready_start", in_ready, 0);
                if (regs_q.size() > 0) check_wide("regs_at_start", fprti_regs, regs_q.pop_front());
                else begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_start: got 1 expected 0");
                end
            end
            last_start = int_start;
            if (res_valid) begin
                check("in_ready_resp", in_ready, 0);
                if (!in_resp) begin
                    in_resp = 1;
                    hd = res_data; hr = res_err; hregs = fprti_regs;
                    if (bp_token != seen_bp) begin
                        seen_bp = bp_token;
                        stall = bp_cycles;
                    end else stall = 0;
                end else begin
                    check("hold_data", res_data, hd);
                    check("hold_err", res_err, hr);
                    check_wide("hold_regs", fprti_regs, hregs);
                end
                if (stall > 0) begin
                    res_ready = 1'b0;
                    stall--;
                end else begin
                    res_ready = 1'b1;
                    // handshake completes at the coming edge
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_result: got %0h err %0b expected none", res_data, res_err);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {res_err, res_data}, e);
                    end
                    in_resp = 0;
                end
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    initial begin : main
        int kind, n, d;
        bit last;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_int_start", int_start, 0);
        check("rst_res_valid", res_valid, 0);
        check_wide("rst_regs", fprti_regs, '0);

        // Clean job
        run_job(N, 1, 20, 32'h4049_0FDB, 0, 1, 1);
        wait_idle();
        // Early last, then a normal job
        run_job(9, 1, 5, 32'h1234_5678, 0, 0, 1);
        wait_idle();
        run_job(N, 1, 4, 32'h3F00_0000, 0, 0, 1);
        wait_idle();
        // Missing last on the final word
        run_job(N, 0, 5, 32'h0BAD_0BAD, 0, 0, 1);
        wait_idle();
        // Early last on the very first word
        run_job(1, 1, 5, 32'h0, 0, 0, 1);
        wait_idle();
        // Backpressure for 10 cycles
        bp_cycles = 10; bp_token++;
        run_job(N, 1, 6, 32'hC0A0_0000, 0, 0, 1);
        wait_idle();
        bp_cycles = 10; bp_token++;
        run_job(7, 1, 6, 32'h0, 0, 0, 1);
        wait_idle();
`ifdef FPRTI_TIMEOUT_EN
        run_job(N, 1, 0, 32'h0, 0, 0, 1);
        wait_idle();
        run_job(N, 1, TMO, 32'h4120_0000, 0, 0, 1);
        wait_idle();
        run_job(N, 1, TMO + 1, 32'h4130_0000, 0, 0, 1);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
`endif
        // Reset mid-load after 7 words, stale int_done in LOAD
        run_job(7, 0, 0, 32'h0, 0, 0, 0);
        pulse_reset();
        check("midload_rst_in_ready", in_ready, 1);
        check("midload_rst_res_valid", res_valid, 0);
        check_wide("midload_rst_regs", fprti_regs, '0);
        stale_tok++;
        repeat (4) @(posedge clk);
        #1;
        run_job(N, 1, 3, 32'h4248_0000, 0, 1, 1);
        wait_idle();
        // Reset during WAIT, late int_done must be ignored
        aborted = 1;
        run_job(N, 1, 20, 32'h5555_AAAA, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        pulse_reset();
        check("midwait_rst_res_valid", res_valid, 0);
        repeat (25) @(posedge clk);
        #1;
        aborted = 0;
        check("midwait_rst_in_ready", in_ready, 1);
        // Gapped input
        run_job(N, 1, 7, 32'h4049_0FDB, 1, 1, 1);
        wait_idle();

        // Randomized jobs
        for (int j = 0; j < 24; j++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)      begin n = $urandom_range(1, N - 1); last = 1; end
            else if (kind == 1) begin n = N; last = 0; end
            else                begin n = N; last = 1; end
`ifdef FPRTI_TIMEOUT_EN
            d = $urandom_range(0, TMO + 3);
`else
            d = $urandom_range(1, 30);
`endif
            bp_cycles = $urandom_range(0, 3); bp_token++;
            run_job(n, last, d, $urandom, bit'($urandom_range(0, 1)), 0, 1);
            wait_idle();
            repeat (4) @(posedge clk);
            #1;
        end

        check("start_count", starts_seen, starts_exp);
        check("pending_results", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fprti_job_loader.md
FPRTI_JOB_LOADER -- requirements
Module: fprti_job_loader

Interface
REQ-001 Parameter NUM_REGS, default 15, meaning the number of 32-bit job words per ray/triangle test.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, meaning the WAIT-state watchdog limit; it is used only when FPRTI_TIMEOUT_EN is defined.
REQ-003 Port clk, input, 1 bit: the single clock.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: upstream job word valid.
REQ-006 Port in_ready, output, 1 bit: loader accepts a job word.
REQ-007 Port in_data, input, 32 bits: IEEE-754 single-precision job word.
REQ-008 Port in_last, input, 1 bit: marks the final word of a job.
REQ-009 Port fprti_regs, output, 32 bits x NUM_REGS: operand array driven to the intersection unit.
REQ-010 Port int_start, output, 1 bit: single-cycle start pulse to the intersection unit.
REQ-011 Port int_done, input, 1 bit: intersection unit result valid.
REQ-012 Port int_result, input, 32 bits: intersection unit return value.
REQ-013 Port res_valid, output, 1 bit: result available downstream.
REQ-014 Port res_ready, input, 1 bit: downstream accepts the result.
REQ-015 Port res_data, output, 32 bits: result word.
REQ-016 Port res_err, output, 1 bit: job error flag (framing error or timeout).

Function
REQ-017 The operand word map SHALL be:
- indices 0-2: ray origin x/y/z
- indices 3-5: ray direction x/y/z
- indices 6-8: p0
- indices 9-11: p1
- indices 12-14: p2
REQ-018 The FSM states SHALL be LOAD, START, WAIT and RESP; the FSM resets to LOAD.
REQ-019 In LOAD, in_ready SHALL be 1, and each in_valid&in_ready handshake writes in_data to fprti_regs[idx] and increments idx.
REQ-020 A handshake with in_last=1 and idx==NUM_REGS-1 SHALL move the FSM to START.
REQ-021 A framing error SHALL move the FSM to RESP with res_err=1 and res_data=32'h0, then reset idx to 0. Framing errors are:
- in_last=1 with idx<NUM_REGS-1
- in_last=0 with idx==NUM_REGS-1
REQ-022 In START, int_start SHALL be 1 for exactly one cycle, followed by WAIT.
REQ-023 In WAIT, int_done=1 SHALL capture int_result into res_data with res_err=0 and move the FSM to RESP.
REQ-024 In RESP, res_valid SHALL be held at 1 with res_data and res_err stable until res_ready=1; the handshake cycle returns the FSM to LOAD with idx=0.
REQ-025 fprti_regs SHALL be unchanged from the START entry cycle until the next LOAD write.
REQ-026 in_ready SHALL be 0 in START, WAIT and RESP.
REQ-027 int_done SHALL be ignored outside WAIT.
REQ-028 Latency from the last-word handshake to int_start SHALL be 1 cycle.
REQ-029 Latency from int_done to res_valid SHALL be 1 cycle.
REQ-030 With res_ready held at 1, a full job SHALL occupy NUM_REGS + 3 + (intersection cycles) cycles.

Reset
REQ-031 Reset SHALL apply on a rising clk edge with rst=1, and rst SHALL override all other inputs in that cycle.
REQ-032 Reset values SHALL be:
- state=LOAD, idx=0
- fprti_regs all 0
- int_start=0, res_valid=0, res_data=0, res_err=0
- in_ready=1 from the first cycle after reset
REQ-033 A reset in any state, including mid-load and WAIT, SHALL abandon the job; no result is emitted and a late int_done is ignored.

Configuration
REQ-034 With FPRTI_TIMEOUT_EN defined:
- a counter clears on WAIT entry and increments each WAIT cycle
- on reaching TIMEOUT_CYCLES with int_done=0, the FSM moves to RESP with res_data=32'hFFFF_FFFF and res_err=1
- int_done in the expiry cycle takes priority
REQ-035 Without FPRTI_TIMEOUT_EN, WAIT SHALL hold indefinitely until int_done, and no counter logic is synthesized.

Structure
REQ-036 Package fprti_pkg SHALL hold:
- FPRTI_NUM_REGS=15
- the FSM state enum
- the operand index constants (RO_X..P2_Z)
- the result constants FPRTI_RES_TIMEOUT=32'hFFFF_FFFF and FPRTI_RES_FRAMING=32'h0
REQ-037 The loader SHALL be a single module with no sub-module; the watchdog counter is inline and guarded by the macro.

Verification
REQ-038 The bench SHALL cover the following scenarios:
- Clean job: 15 words (0x3F800000..) with in_last on word 15, int_done after 20 cycles with 0x40490FDB -> one int_start pulse, fprti_regs match the inputs, res_data=0x40490FDB, res_err=0.
- Early last: in_last on word 9 -> no int_start, res_valid with res_err=1 and res_data=0; the next 15-word job then completes normally.
- Backpressure: res_ready held at 0 for 10 cycles -> res_valid, res_data and res_err stable throughout, in_ready=0, fprti_regs unchanged.
- Timeout (macro defined, TIMEOUT_CYCLES=8): int_done never asserted -> res_data=0xFFFFFFFF and res_err=1 exactly 8 cycles after WAIT entry; int_done in that same cycle -> the normal result instead.
- Reset mid-load: rst after word 7, then a full job -> fprti_regs were 0 after reset, the new job loads from index 0, and a stale int_done during LOAD is ignored.
- Gaps: in_valid toggled every other cycle -> the correct index order is preserved and the result is unchanged.
